// File: rtl/mprj_io_bank.sv
// mprj_io_bank: clocked GPIO pad bank with 2-flop input synchronisers, per-pad edge
// detection and sticky maskable IRQ status; glitch filter built only under MPRJ_IO_GLITCH_FILTER_EN.
module mprj_io_bank #(
    parameter int   NPADS       = 38,
    parameter int   FLT_W       = 4,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    inout  wire  [NPADS-1:0] pad_io,
    input  logic [NPADS-1:0] io_out_i,
    input  logic [NPADS-1:0] oeb_i,
    output logic [NPADS-1:0] io_in_o,
    input  logic [FLT_W-1:0] filter_len_i,
    input  logic [NPADS-1:0] irq_rise_en_i,
    input  logic [NPADS-1:0] irq_fall_en_i,
    input  logic [NPADS-1:0] irq_mask_i,
    input  logic [NPADS-1:0] irq_clr_i,
    output logic [NPADS-1:0] irq_status_o,
    output logic             irq_o
);
    localparam logic [NPADS-1:0] IN_RST = {NPADS{RESET_LEVEL}};

    logic [NPADS-1:0] out_q;
    logic [NPADS-1:0] oeb_q;
    logic [NPADS-1:0] s1;
    logic [NPADS-1:0] s2;
    logic [NPADS-1:0] filt;
    logic [NPADS-1:0] filt_d;
    logic [NPADS-1:0] rise;
    logic [NPADS-1:0] fall;
    logic [NPADS-1:0] status_q;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            out_q <= '0;
            oeb_q <= '1;
        end else begin
            out_q <= io_out_i;
            oeb_q <= oeb_i;
        end
    end

    // Reset forces oeb_q high asynchronously, so pads release without a clock.
    for (genvar i = 0; i < NPADS; i++) begin : g_pad
        assign pad_io[i] = oeb_q[i] ? 1'bz : out_q[i];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            s1 <= IN_RST;
            s2 <= IN_RST;
        end else begin
            s1 <= pad_io;
            s2 <= s1;
        end
    end

`ifdef MPRJ_IO_GLITCH_FILTER_EN
    localparam logic [FLT_W:0]   CNT_ONE_W = (FLT_W+1)'(1);
    localparam logic [FLT_W-1:0] CNT_ONE   = FLT_W'(1);

    logic [FLT_W-1:0] cnt [NPADS];

    // NOTE: the counter array is per-pad flops, not a RAM, so it is reset with everything else.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            filt <= IN_RST;
            for (int i = 0; i < NPADS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NPADS; i++) begin
                if (s2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (({1'b0, cnt[i]} + CNT_ONE_W) >= {1'b0, filter_len_i}) begin
                    filt[i] <= s2[i];
                    cnt[i]  <= '0;
                end else if (cnt[i] != '1) begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end
`else
    logic unused_filter_len;
    assign unused_filter_len = ^filter_len_i;
    assign filt              = s2;
`endif

    assign io_in_o = filt;

    // filt_d resets equal to filt, so leaving reset never looks like an edge.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            filt_d <= IN_RST;
        end else begin
            filt_d <= filt;
        end
    end

    assign rise = filt & ~filt_d;
    assign fall = ~filt & filt_d;

    // The OR of new edges is applied after the clear, so a same-cycle edge keeps the bit set.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            status_q <= '0;
            irq_o    <= 1'b0;
        end else begin
            status_q <= (status_q & ~irq_clr_i) | (rise & irq_rise_en_i) | (fall & irq_fall_en_i);
            irq_o    <= |(status_q & irq_mask_i);
        end
    end

    assign irq_status_o = status_q;

endmodule

// File: tb/tb_mprj_io_bank.sv
// Directed bench for mprj_io_bank: reset, output path, filter, IRQ mask, set/clear collision, async reset.
module tb_mprj_io_bank;
    localparam int NPADS = 38;
    localparam int FLT_W = 4;
`ifdef MPRJ_IO_GLITCH_FILTER_EN
    localparam int FLT_EXTRA = 1;
`else
    localparam int FLT_EXTRA = 0;
`endif
    localparam logic [NPADS-1:0] ALL1 = '1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    wire  [NPADS-1:0] pad;
    logic [NPADS-1:0] io_out;
    logic [NPADS-1:0] oeb;
    logic [NPADS-1:0] io_in;
    logic [FLT_W-1:0] filter_len;
    logic [NPADS-1:0] rise_en;
    logic [NPADS-1:0] fall_en;
    logic [NPADS-1:0] mask;
    logic [NPADS-1:0] clr;
    logic [NPADS-1:0] status;
    logic             irq;
    logic [NPADS-1:0] drv_en;
    logic [NPADS-1:0] drv_val;
    int               n_checks = 0;
    int               n_fail = 0;

    // External board: pull-up on every pad plus an optional bench driver.
    for (genvar i = 0; i < NPADS; i++) begin : g_board
        pullup pu (pad[i]);
        assign pad[i] = drv_en[i] ? drv_val[i] : 1'bz;
    end

    mprj_io_bank #(.NPADS(NPADS), .FLT_W(FLT_W), .RESET_LEVEL(1'b1)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .pad_io        (pad),
        .io_out_i      (io_out),
        .oeb_i         (oeb),
        .io_in_o       (io_in),
        .filter_len_i  (filter_len),
        .irq_rise_en_i (rise_en),
        .irq_fall_en_i (fall_en),
        .irq_mask_i    (mask),
        .irq_clr_i     (clr),
        .irq_status_o  (status),
        .irq_o         (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        io_out = '0; oeb = '1; filter_len = '0; rise_en = '0; fall_en = '0;
        mask = '0; clr = '0; drv_en = '0; drv_val = '0;
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (status !== '0) begin n_fail++; $display("FAIL reset_status_held: got %h want 0", status); end
        #2 rst = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (pad !== ALL1) begin n_fail++; $display("FAIL reset_pad_pullup: got %h want %h", pad, ALL1); end
        n_checks++;
        if (io_in !== ALL1) begin n_fail++; $display("FAIL reset_io_in: got %h want %h", io_in, ALL1); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
        n_checks++;
        if (status !== '0) begin n_fail++; $display("FAIL reset_status: got %h want 0", status); end
    endtask

    task automatic test_output_path();
        logic exp_n3;
        oeb[3] = 1'b0; io_out[3] = 1'b0;
        n_checks++;
        if (pad[3] !== 1'b1) begin n_fail++; $display("FAIL out_before_edge: got %b want 1", pad[3]); end
        tick();
        n_checks++;
        if (pad[3] !== 1'b0) begin n_fail++; $display("FAIL out_pad_n1: got %b want 0", pad[3]); end
        n_checks++;
        if (io_in[3] !== 1'b1) begin n_fail++; $display("FAIL out_in_n1: got %b want 1", io_in[3]); end
        tick();
        n_checks++;
        if (io_in[3] !== 1'b1) begin n_fail++; $display("FAIL out_in_n2: got %b want 1", io_in[3]); end
        tick();
        exp_n3 = (FLT_EXTRA == 1) ? 1'b1 : 1'b0;
        n_checks++;
        if (io_in[3] !== exp_n3) begin n_fail++; $display("FAIL out_in_n3: got %b want %b", io_in[3], exp_n3); end
        tick();
        n_checks++;
        if (io_in[3] !== 1'b0) begin n_fail++; $display("FAIL out_in_n4: got %b want 0", io_in[3]); end
        n_checks++;
        if (status !== '0) begin n_fail++; $display("FAIL out_no_status: got %h want 0", status); end
        oeb[3] = 1'b1;
        repeat (6) tick();
        n_checks++;
        if (io_in[3] !== 1'b1) begin n_fail++; $display("FAIL out_release: got %b want 1", io_in[3]); end
    endtask

`ifdef MPRJ_IO_GLITCH_FILTER_EN
    task automatic test_glitch_filter();
        logic exp_in;
        logic exp_st;
        filter_len = 4'd4; fall_en[5] = 1'b1;
        drv_val[5] = 1'b0; drv_en[5] = 1'b1;
        repeat (3) tick();
        drv_en[5] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if (io_in[5] !== 1'b1) begin n_fail++; $display("FAIL flt_short_in c%0d: got %b want 1", c, io_in[5]); end
        end
        n_checks++;
        if (status[5] !== 1'b0) begin n_fail++; $display("FAIL flt_short_status: got %b want 0", status[5]); end
        drv_en[5] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 6) drv_en[5] = 1'b0;
            exp_in = (c >= 6) ? 1'b0 : 1'b1;
            exp_st = (c >= 7) ? 1'b1 : 1'b0;
            n_checks++;
            if (io_in[5] !== exp_in) begin n_fail++; $display("FAIL flt_long_in c%0d: got %b want %b", c, io_in[5], exp_in); end
            n_checks++;
            if (status[5] !== exp_st) begin n_fail++; $display("FAIL flt_long_status c%0d: got %b want %b", c, status[5], exp_st); end
        end
        repeat (6) tick();
        n_checks++;
        if (io_in[5] !== 1'b1) begin n_fail++; $display("FAIL flt_recover: got %b want 1", io_in[5]); end
        clr[5] = 1'b1;
        tick();
        clr[5] = 1'b0;
        n_checks++;
        if (status[5] !== 1'b0) begin n_fail++; $display("FAIL flt_clear: got %b want 0", status[5]); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL flt_irq_unmasked: got %b want 0", irq); end
        filter_len = '0; fall_en[5] = 1'b0;
    endtask
`else
    task automatic test_filter_bypass();
        logic exp_in;
        logic exp_st;
        filter_len = 4'd4; fall_en[5] = 1'b1;
        drv_val[5] = 1'b0; drv_en[5] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 3) drv_en[5] = 1'b0;
            exp_in = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            exp_st = (c >= 3) ? 1'b1 : 1'b0;
            n_checks++;
            if (io_in[5] !== exp_in) begin n_fail++; $display("FAIL byp_in c%0d: got %b want %b", c, io_in[5], exp_in); end
            n_checks++;
            if (status[5] !== exp_st) begin n_fail++; $display("FAIL byp_status c%0d: got %b want %b", c, status[5], exp_st); end
        end
        clr[5] = 1'b1;
        tick();
        clr[5] = 1'b0;
        n_checks++;
        if (status[5] !== 1'b0) begin n_fail++; $display("FAIL byp_clear: got %b want 0", status[5]); end
        filter_len = '0; fall_en[5] = 1'b0;
    endtask
`endif

    task automatic test_mask_irq();
        logic [NPADS-1:0] exp_v;
        rise_en[7] = 1'b1; mask[7] = 1'b0;
        drv_val[7] = 1'b0; drv_en[7] = 1'b1;
        repeat (6) tick();
        n_checks++;
        if (io_in[7] !== 1'b0) begin n_fail++; $display("FAIL mask_low: got %b want 0", io_in[7]); end
        drv_en[7] = 1'b0;
        repeat (6) tick();
        exp_v = '0; exp_v[7] = 1'b1;
        n_checks++;
        if (status !== exp_v) begin n_fail++; $display("FAIL mask_status: got %h want %h", status, exp_v); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_irq_off: got %b want 0", irq); end
        mask[7] = 1'b1;
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_irq_pre_edge: got %b want 0", irq); end
        tick();
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL mask_irq_on: got %b want 1", irq); end
        clr[7] = 1'b1;
        tick();
        clr[7] = 1'b0;
        n_checks++;
        if (status[7] !== 1'b0) begin n_fail++; $display("FAIL mask_clear: got %b want 0", status[7]); end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL mask_irq_lag: got %b want 1", irq); end
        tick();
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_irq_drop: got %b want 0", irq); end
        rise_en[7] = 1'b0; mask[7] = 1'b0;
    endtask

    task automatic test_set_clear_collision();
        rise_en[2] = 1'b1; mask[2] = 1'b1;
        drv_val[2] = 1'b0; drv_en[2] = 1'b1;
        repeat (6) tick();
        n_checks++;
        if (io_in[2] !== 1'b0) begin n_fail++; $display("FAIL coll_low: got %b want 0", io_in[2]); end
        drv_en[2] = 1'b0;
        repeat (2 + FLT_EXTRA) tick();
        n_checks++;
        if (status[2] !== 1'b0) begin n_fail++; $display("FAIL coll_pre: got %b want 0", status[2]); end
        clr[2] = 1'b1;
        tick();
        n_checks++;
        if (status[2] !== 1'b1) begin n_fail++; $display("FAIL coll_set_wins: got %b want 1", status[2]); end
        tick();
        clr[2] = 1'b0;
        n_checks++;
        if (status[2] !== 1'b0) begin n_fail++; $display("FAIL coll_cleared: got %b want 0", status[2]); end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL coll_irq_on: got %b want 1", irq); end
        tick();
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL coll_irq_off: got %b want 0", irq); end
        rise_en[2] = 1'b0; mask[2] = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [NPADS-1:0] exp_v;
        fall_en[7:0] = 8'hFF;
        oeb[0] = 1'b0; io_out[0] = 1'b0;
        drv_val[7:1] = 7'h00; drv_en[7:1] = 7'h7F;
        repeat (8) tick();
        exp_v = '0; exp_v[7:0] = 8'hFF;
        n_checks++;
        if (pad[0] !== 1'b0) begin n_fail++; $display("FAIL arst_pad_driven: got %b want 0", pad[0]); end
        n_checks++;
        if (status !== exp_v) begin n_fail++; $display("FAIL arst_status_ff: got %h want %h", status, exp_v); end
        mask[7:0] = 8'hFF;
        tick();
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL arst_irq_pre: got %b want 1", irq); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (pad[0] !== 1'b1) begin n_fail++; $display("FAIL arst_pad_release: got %b want 1", pad[0]); end
        n_checks++;
        if (status !== '0) begin n_fail++; $display("FAIL arst_status: got %h want 0", status); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL arst_irq: got %b want 0", irq); end
        n_checks++;
        if (io_in !== ALL1) begin n_fail++; $display("FAIL arst_io_in: got %h want %h", io_in, ALL1); end
        drv_en = '0; oeb = '1; io_out = '0; fall_en = '0; mask = '0;
        tick();
        #2 rst = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (status !== '0) begin n_fail++; $display("FAIL arst_release_status: got %h want 0", status); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL arst_release_irq: got %b want 0", irq); end
    endtask

    initial begin
        test_reset();
        test_output_path();
`ifdef MPRJ_IO_GLITCH_FILTER_EN
        test_glitch_filter();
`else
        test_filter_bypass();
`endif
        test_mask_irq();
        test_set_clear_collision();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
